scan_hex_led_capture: RTL and testbench

- Decoder counterpart of the team's multiplexed hex display scanner (`scan_hex_led_disp`).
- Samples a scanned 4-digit bus (en, sseg) and reconstructs per-digit hex value, decimal point and blank state.
- Publishes a coherent 4-digit frame when all digits have been captured.
- Used for loopback self-check of display paths (one instance per 4-digit group) and as a bench monitor.

---
 rtl/scan_hex_led_capture.sv | 270 +++++++++++++++++++++++++++
 tb/tb_scan_hex_led_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_hex_led_capture.sv
// Decoder for a multiplexed 4-digit seven-segment bus.
// Each digit is captured once it has been stable for SETTLE_CYC synchronized
// samples. A coherent frame is published once all four digits have been seen.
// 'lost' flags a bus that has stopped producing frames.
module scan_hex_led_capture #(
    parameter int SETTLE_CYC     = 16,
    parameter int TIMEOUT_CYC    = 2000000,
    parameter int EN_ACTIVE_LOW  = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp,
    output logic [3:0] blank,
    output logic       frame_valid,
    output logic       glyph_err,
    output logic       lost
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    logic [3:0]  en_s1_reg, en_s2_reg;
    logic [7:0]  seg_s1_reg, seg_s2_reg;
    logic [3:0]  en_n;
    logic [7:0]  seg_n;
    logic [11:0] sample;
    logic        samp_valid;

    state_t      state_reg, state_next;
    logic [11:0] cand_reg, cand_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] count_inc;
    logic        capture;

    logic [3:0]  dig_sel;
    logic [3:0]  dec_nib;
    logic        dec_dp;
    logic        dec_blank;
    logic        dec_err;

    logic [3:0]  seen_reg;
    logic [3:0]  seen_hit;
    logic        shadow_err_reg;
    logic        frame_done;

    logic        frame_valid_reg;
    logic        glyph_err_reg;
    logic        lost_reg;
    logic [TW-1:0] timer_reg;

    logic [15:0] hex_all;
    logic [3:0]  dp_all;
    logic [3:0]  blank_all;

    // Two-flop synchronizer on the raw scan bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_s1_reg  <= 4'b0;
            en_s2_reg  <= 4'b0;
            seg_s1_reg <= 8'b0;
            seg_s2_reg <= 8'b0;
        end else begin
            en_s1_reg  <= en;
            en_s2_reg  <= en_s1_reg;
            seg_s1_reg <= sseg;
            seg_s2_reg <= seg_s1_reg;
        end
    end

    // Normalize polarity so everything downstream is active-high
    assign en_n       = (EN_ACTIVE_LOW != 0)  ? ~en_s2_reg  : en_s2_reg;
    assign seg_n      = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_reg : seg_s2_reg;
    assign sample     = {en_n, seg_n};
    assign samp_valid = (en_n != 4'b0) && ((en_n & (en_n - 4'd1)) == 4'b0);
    assign count_inc  = count_reg + CNT_ONE;

    // Settle FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_WAIT;
            cand_reg  <= 12'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            count_reg <= count_next;
        end
    end

    // Settle FSM: track a stable candidate and fire one capture per stable run
    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        count_next = count_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (samp_valid) begin
                    cand_next  = sample;
                    count_next = CNT_ONE;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!samp_valid) begin
                    state_next = ST_WAIT;
                end else if (sample != cand_reg) begin
                    cand_next  = sample;
                    count_next = CNT_ONE;
                end else begin
                    count_next = count_inc;
                    if (count_inc == CNT_MAX) begin
                        capture    = 1'b1;
                        state_next = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!samp_valid) begin
                    state_next = ST_WAIT;
                end else if (sample != cand_reg) begin
                    cand_next  = sample;
                    count_next = CNT_ONE;
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    assign dig_sel = cand_reg[11:8];
    assign dec_dp  = cand_reg[7];

    // Glyph decode of the candidate's a..g pattern
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (cand_reg[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign seen_hit   = seen_reg | dig_sel;
    assign frame_done = capture && (seen_hit == 4'b1111);

    // Frame bookkeeping: seen mask, sticky glyph error and the publish pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_reg        <= 4'b0;
            shadow_err_reg  <= 1'b0;
            glyph_err_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            frame_valid_reg <= frame_done;
            if (frame_done) begin
                seen_reg       <= 4'b0;
                shadow_err_reg <= 1'b0;
                glyph_err_reg  <= shadow_err_reg | dec_err;
            end else if (capture) begin
                seen_reg       <= seen_hit;
                shadow_err_reg <= shadow_err_reg | dec_err;
            end
        end
    end

    // Frame watchdog; a completing frame wins over the threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= '0;
            lost_reg  <= 1'b0;
        end else if (frame_done) begin
            timer_reg <= '0;
            lost_reg  <= 1'b0;
        end else if (timer_reg != T_MAX) begin
            timer_reg <= timer_reg + TW'(1);
            if (timer_reg == T_LAST) begin
                lost_reg <= 1'b1;
            end
        end
    end

    // Per-digit shadow slot and published copy
    for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
        logic [3:0] sh_hex_reg;
        logic       sh_dp_reg;
        logic       sh_blank_reg;
        logic [3:0] out_hex_reg;
        logic       out_dp_reg;
        logic       out_blank_reg;
        logic       hit;

        assign hit = capture && dig_sel[gi];

        // Shadow slot: overwritten on every capture of this digit
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sh_hex_reg   <= 4'h0;
                sh_dp_reg    <= 1'b0;
                sh_blank_reg <= 1'b0;
            end else if (hit) begin
                sh_hex_reg   <= dec_nib;
                sh_dp_reg    <= dec_dp;
                sh_blank_reg <= dec_blank;
            end
        end

        // Published copy: bypass the slot being captured on the completing edge
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_hex_reg   <= 4'h0;
                out_dp_reg    <= 1'b0;
                out_blank_reg <= 1'b0;
            end else if (frame_done) begin
                out_hex_reg   <= hit ? dec_nib   : sh_hex_reg;
                out_dp_reg    <= hit ? dec_dp    : sh_dp_reg;
                out_blank_reg <= hit ? dec_blank : sh_blank_reg;
            end
        end

        assign hex_all[gi*4 +: 4] = out_hex_reg;
        assign dp_all[gi]         = out_dp_reg;
        assign blank_all[gi]      = out_blank_reg;
    end

    assign hex0        = hex_all[3:0];
    assign hex1        = hex_all[7:4];
    assign hex2        = hex_all[11:8];
    assign hex3        = hex_all[15:12];
    assign dp          = dp_all;
    assign blank       = blank_all;
    assign frame_valid = frame_valid_reg;
    assign glyph_err   = glyph_err_reg;
    assign lost        = lost_reg;

endmodule

// File: tb/tb_scan_hex_led_capture.sv
// Bench for scan_hex_led_capture: an active-high instance and an active-low
// instance share one stimulus (inverted for the latter) and are held to the
// same expected results.
module tb_scan_hex_led_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic [7:0] sseg;
    logic [3:0] en_inv;
    logic [7:0] sseg_inv;

    assign en_inv   = ~en;
    assign sseg_inv = ~sseg;

    logic [3:0] hex3, hex2, hex1, hex0, dp, blank;
    logic       frame_valid, glyph_err, lost;
    logic [3:0] hex3_i, hex2_i, hex1_i, hex0_i, dp_i, blank_i;
    logic       frame_valid_i, glyph_err_i, lost_i;

    scan_hex_led_capture #(
        .SETTLE_CYC(4), .TIMEOUT_CYC(200), .EN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sseg(sseg),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .dp(dp), .blank(blank), .frame_valid(frame_valid),
        .glyph_err(glyph_err), .lost(lost)
    );

    scan_hex_led_capture #(
        .SETTLE_CYC(4), .TIMEOUT_CYC(200), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut_inv (
        .clk(clk), .reset(reset), .en(en_inv), .sseg(sseg_inv),
        .hex3(hex3_i), .hex2(hex2_i), .hex1(hex1_i), .hex0(hex0_i),
        .dp(dp_i), .blank(blank_i), .frame_valid(frame_valid_i),
        .glyph_err(glyph_err_i), .lost(lost_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int fv_total   = 0;
    int fv_total_i = 0;
    int fv_base    = 0;
    int fv_base_i  = 0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1)   fv_total   <= fv_total + 1;
        if (frame_valid_i === 1'b1) fv_total_i <= fv_total_i + 1;
    end

    typedef struct {
        logic [31:0] segs;   // {d3, d2, d1, d0}
        logic [15:0] hex;    // {hex3, hex2, hex1, hex0}
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [7:0] seg, input int n);
        en   = 4'b0001 << idx;
        sseg = seg;
        step(n);
    endtask

    task automatic mark_fv();
        fv_base   = fv_total;
        fv_base_i = fv_total_i;
    endtask

    task automatic check_fv(input string tag, input int exp);
        check({tag, ".frames"},     32'(fv_total - fv_base),     32'(exp));
        check({tag, ".frames_inv"}, 32'(fv_total_i - fv_base_i), 32'(exp));
    endtask

    task automatic check_frame(input string tag, input logic [15:0] eh, input logic [3:0] edp,
                               input logic [3:0] eb, input logic ee);
        check({tag, ".hex"},       32'({hex3, hex2, hex1, hex0}),         32'(eh));
        check({tag, ".dp"},        32'(dp),                               32'(edp));
        check({tag, ".blank"},     32'(blank),                            32'(eb));
        check({tag, ".glyph_err"}, 32'(glyph_err),                        32'(ee));
        check({tag, ".hex_inv"},   32'({hex3_i, hex2_i, hex1_i, hex0_i}), 32'(eh));
        check({tag, ".dp_inv"},    32'(dp_i),                             32'(edp));
        check({tag, ".blank_inv"}, 32'(blank_i),                          32'(eb));
        check({tag, ".gerr_inv"},  32'(glyph_err_i),                      32'(ee));
    endtask

    task automatic check_idle_zero(input string tag);
        check_frame(tag, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        check({tag, ".fv"},       32'(frame_valid),   32'(0));
        check({tag, ".lost"},     32'(lost),          32'(0));
        check({tag, ".fv_inv"},   32'(frame_valid_i), 32'(0));
        check({tag, ".lost_inv"}, 32'(lost_i),        32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{32'h664F5B06, 16'h4321, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{32'h3F80BF3F, 16'h0000, 4'b0110, 4'b0100, 1'b0};
        vecs[2] = '{32'h555B063F, 16'h0210, 4'b0000, 4'b0000, 1'b1};
        vecs[3] = '{32'h6F7F077D, 16'h9876, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{32'h5E397C77, 16'hDCBA, 4'b0000, 4'b0000, 1'b0};
        vecs[5] = '{32'h006D7179, 16'h05FE, 4'b0000, 4'b1000, 1'b0};
        vecs[6] = '{32'hE6CFDB86, 16'h4321, 4'b1111, 4'b0000, 1'b0};
        vecs[7] = '{32'h06060806, 16'h1101, 4'b0000, 4'b0000, 1'b1};

        // Reset state
        reset = 1'b1;
        en    = 4'b0000;
        sseg  = 8'h00;
        step(3);
        check_idle_zero("reset");
        reset = 1'b0;
        step(2);

        // Table-driven frames: scan digits 0..3, 10 cycles each
        for (int v = 0; v < 8; v++) begin
            mark_fv();
            for (int d = 0; d < 4; d++) begin
                drive_digit(d, vecs[v].segs[d*8 +: 8], 10);
            end
            check_fv($sformatf("vec%0d", v), 1);
            check_frame($sformatf("vec%0d", v), vecs[v].hex, vecs[v].dp, vecs[v].blank, vecs[v].err);
            $display("vec %0d: segs=%h hex=%h dp=%b blank=%b glyph_err=%b",
                     v, vecs[v].segs, {hex3, hex2, hex1, hex0}, dp, blank, glyph_err);
        end

        // Short digit and ghost: no capture from a 3-cycle hold or en=0011
        mark_fv();
        drive_digit(1, 8'h06, 10);
        drive_digit(2, 8'h5B, 10);
        drive_digit(3, 8'h4F, 10);
        drive_digit(0, 8'h7F, 3);
        en = 4'b0011; sseg = 8'h66; step(5);
        en = 4'b0000; step(6);
        check_fv("short", 0);
        check_frame("short_hold", 16'h1101, 4'b0000, 4'b0000, 1'b1);
        $display("short/ghost: frames=%0d hex=%h", fv_total - fv_base, {hex3, hex2, hex1, hex0});

        // Pin-to-capture latency: frame_valid appears exactly 2+SETTLE_CYC cycles later
        drive_digit(0, 8'h66, 5);
        check("lat.early",     32'(frame_valid),   32'(0));
        check("lat.early_inv", 32'(frame_valid_i), 32'(0));
        step(1);
        check("lat.fv",     32'(frame_valid),   32'(1));
        check("lat.fv_inv", 32'(frame_valid_i), 32'(1));
        check_frame("lat", 16'h3214, 4'b0000, 4'b0000, 1'b0);
        $display("latency: fv=%b hex=%h", frame_valid, {hex3, hex2, hex1, hex0});

        // Timeout: lost exactly 200 cycles after that frame_valid
        en = 4'b0000;
        k = 0;
        while (lost !== 1'b1 && k < 300) begin
            step(1);
            k++;
        end
        check("timeout.delay",    32'(k),      32'(200));
        check("timeout.lost_inv", 32'(lost_i), 32'(1));
        check_frame("timeout_hold", 16'h3214, 4'b0000, 4'b0000, 1'b0);
        $display("timeout: lost after %0d cycles", k);

        // Resume scanning: lost clears together with the next frame_valid
        drive_digit(0, 8'h06, 10);
        drive_digit(1, 8'h5B, 10);
        drive_digit(2, 8'h4F, 10);
        check("resume.still_lost", 32'(lost), 32'(1));
        en = 4'b1000; sseg = 8'h66;
        k = 0;
        while (frame_valid !== 1'b1 && k < 30) begin
            step(1);
            k++;
        end
        check("resume.fv",       32'(frame_valid),   32'(1));
        check("resume.fv_inv",   32'(frame_valid_i), 32'(1));
        check("resume.lost",     32'(lost),          32'(0));
        check("resume.lost_inv", 32'(lost_i),        32'(0));
        check_frame("resume", 16'h4321, 4'b0000, 4'b0000, 1'b0);
        $display("resume: fv=%b lost=%b hex=%h", frame_valid, lost, {hex3, hex2, hex1, hex0});
        step(5);

        // Reset after 3 digits: outputs clear at once, partial frame discarded
        drive_digit(0, 8'h7D, 10);
        drive_digit(1, 8'h07, 10);
        drive_digit(2, 8'h7F, 10);
        #2 reset = 1'b1;
        #1 check_idle_zero("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        mark_fv();
        drive_digit(3, 8'h6F, 10);
        check_fv("postreset_d3", 0);
        check("postreset.hex", 32'({hex3, hex2, hex1, hex0}), 32'(0));
        drive_digit(0, 8'h7D, 10);
        drive_digit(1, 8'h07, 10);
        drive_digit(2, 8'h7F, 10);
        check_fv("postreset", 1);
        check_frame("postreset", 16'h9876, 4'b0000, 4'b0000, 1'b0);
        $display("post-reset frame: hex=%h", {hex3, hex2, hex1, hex0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
